// File: rtl/stream_pkg.sv
// Shared types and constants for the stream packer: output buffer state
// encoding and the dropped-word counter width.
package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry output buffer. The head entry drives the output; the tail entry
// holds one extra word. A push into a full, stalled buffer is reported as a drop.
module stream_skid2
  import stream_pkg::*;
#(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_dv,
  output logic          o_drop
);

  buf_state_t    r_state;
  buf_state_t    w_state_nxt;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic          w_pop;

  assign w_pop = (r_state != EMPTY) && i_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (i_push) w_state_nxt = ONE;
      ONE: begin
        if (i_push && !w_pop) w_state_nxt = FULL;
        else if (!i_push && w_pop) w_state_nxt = EMPTY;
      end
      FULL: if (w_pop && !i_push) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: the two data entries are reset too; at two words this is cheap and keeps DOUT defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        EMPTY: if (i_push) r_head <= i_data;
        ONE: begin
          if (i_push && w_pop) r_head <= i_data;
          else if (i_push) r_tail <= i_data;
        end
        FULL: begin
          // A push while full only lands if the head leaves in the same cycle.
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_dv   = 1'b0;
    o_data = '0;
    o_drop = 1'b0;
    case (r_state)
      ONE: begin
        o_dv   = 1'b1;
        o_data = r_head;
      end
      FULL: begin
        o_dv   = 1'b1;
        o_data = r_head;
        o_drop = i_push && !i_rdy;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stream_packer.sv
// Packs IN_WIDTH-bit samples into RATIO-lane words (first sample in lane 0)
// and feeds them through a 2-entry output buffer. Optional build macro:
// STREAM_PACKER_DROP_CNT_EN adds the saturating DROP_CNT output.
module stream_packer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 2,
  parameter int RATIO    = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [IN_WIDTH-1:0]       DIN,
  input  logic                      DIN_DV,
  input  logic                      FLUSH,
  output logic [IN_WIDTH*RATIO-1:0] DOUT,
  output logic [$clog2(RATIO):0]    DOUT_CNT,
  output logic                      DOUT_DV,
  input  logic                      DOUT_RDY,
  output logic                      OVERFLOW,
  input  logic                      OVF_CLR
`ifdef STREAM_PACKER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]     DROP_CNT
`endif
);

  localparam int OW = IN_WIDTH * RATIO;
  localparam int LW = $clog2(RATIO);
  localparam int CW = LW + 1;

  logic [LW-1:0]    r_lane;
  logic [OW-1:0]    r_acc;
  logic [OW-1:0]    w_word;
  logic [CW-1:0]    w_fill;
  logic             w_last;
  logic             w_push;
  logic             w_drop;
  logic [CW+OW-1:0] w_buf_out;
  logic             r_overflow;

  // The current sample is merged before the push decision, so a FLUSH in the
  // same cycle as DIN_DV carries that sample.
  always_comb begin
    w_word = r_acc;
    if (DIN_DV) w_word[int'(r_lane)*IN_WIDTH +: IN_WIDTH] = DIN;
  end

  assign w_last = DIN_DV && (r_lane == LW'(RATIO - 1));
  assign w_fill = {1'b0, r_lane} + CW'(DIN_DV);
  assign w_push = w_last || (FLUSH && (w_fill != '0));

  // The accumulator is cleared on every push so unused lanes of a flushed word read zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (w_push) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (DIN_DV) begin
      r_lane <= r_lane + LW'(1);
      r_acc  <= w_word;
    end
  end

  stream_skid2 #(
    .DW(CW + OW)
  ) u_skid (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_push (w_push),
    .i_data ({w_fill, w_word}),
    .i_rdy  (DOUT_RDY),
    .o_data (w_buf_out),
    .o_dv   (DOUT_DV),
    .o_drop (w_drop)
  );

  assign {DOUT_CNT, DOUT} = w_buf_out;

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (OVF_CLR) begin
      r_overflow <= 1'b0;
    end
  end

  assign OVERFLOW = r_overflow;

`ifdef STREAM_PACKER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drop_cnt <= '0;
    end else if (OVF_CLR) begin
      r_drop_cnt <= DROP_CNT_W'(w_drop);
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign DROP_CNT = r_drop_cnt;
`else
  // Without the counter, dropped words are visible only through OVERFLOW.
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (IN_WIDTH=2, RATIO=4); every
// word the bench expects is queued when stimulus is driven and popped on handshake.
module tb_stream_packer;

  localparam int IN_WIDTH = 2;
  localparam int RATIO    = 4;
  localparam int OW       = IN_WIDTH * RATIO;
  localparam int CW       = $clog2(RATIO) + 1;

  logic                CLK      = 1'b0;
  logic                RST_N    = 1'b0;
  logic [IN_WIDTH-1:0] DIN      = '0;
  logic                DIN_DV   = 1'b0;
  logic                FLUSH    = 1'b0;
  logic                DOUT_RDY = 1'b0;
  logic                OVF_CLR  = 1'b0;
  logic [OW-1:0]       DOUT;
  logic [CW-1:0]       DOUT_CNT;
  logic                DOUT_DV;
  logic                OVERFLOW;
`ifdef STREAM_PACKER_DROP_CNT_EN
  logic [15:0]         DROP_CNT;
`endif

  int checks   = 0;
  int failures = 0;
  logic [CW+OW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  stream_packer #(
    .IN_WIDTH(IN_WIDTH),
    .RATIO   (RATIO)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .DIN_DV   (DIN_DV),
    .FLUSH    (FLUSH),
    .DOUT     (DOUT),
    .DOUT_CNT (DOUT_CNT),
    .DOUT_DV  (DOUT_DV),
    .DOUT_RDY (DOUT_RDY),
    .OVERFLOW (OVERFLOW),
    .OVF_CLR  (OVF_CLR)
`ifdef STREAM_PACKER_DROP_CNT_EN
    ,
    .DROP_CNT (DROP_CNT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // One sample (or idle/flush) per call; returns 1 time unit after the consuming edge.
  task automatic drive(input logic [IN_WIDTH-1:0] d, input logic dv, input logic fl);
    DIN    = d;
    DIN_DV = dv;
    FLUSH  = fl;
    @(posedge CLK);
    #1;
    DIN    = '0;
    DIN_DV = 1'b0;
    FLUSH  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Scoreboard: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge CLK) begin
    if (RST_N && DOUT_DV && DOUT_RDY) begin
      checks++;
      assert (exp_q.size() != 0)
        else begin
          failures++;
          $error("FAIL sb_unexpected_word observed=0x%0h expected=none", {DOUT_CNT, DOUT});
        end
      if (exp_q.size() != 0) check("sb_word", 32'({DOUT_CNT, DOUT}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_dv", 32'(DOUT_DV), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_cnt", 32'(DOUT_CNT), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
`ifdef STREAM_PACKER_DROP_CNT_EN
    check("rst_drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
    @(posedge CLK);
    #1;
    RST_N    = 1'b1;
    DOUT_RDY = 1'b1;
    tick(1);

    // Basic packing 1,2,3,0 -> 8'h39 one cycle after the last sample, for one cycle
    drive(2'd1, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    check("pack_no_early_dv", 32'(DOUT_DV), 32'd0);
    exp_q.push_back({3'd4, 8'h39});
    drive(2'd0, 1'b1, 1'b0);
    check("pack_dv", 32'(DOUT_DV), 32'd1);
    check("pack_dout", 32'(DOUT), 32'h39);
    check("pack_cnt", 32'(DOUT_CNT), 32'd4);
    tick(1);
    check("pack_dv_one_cycle", 32'(DOUT_DV), 32'd0);
    check("pack_empty_dout", 32'(DOUT), 32'd0);

    // Flush of a 3-lane partial word, then flush with an empty lane counter
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    exp_q.push_back({3'd3, 8'h3F});
    drive(2'd0, 1'b0, 1'b1);
    check("flush_dv", 32'(DOUT_DV), 32'd1);
    check("flush_dout", 32'(DOUT), 32'h3F);
    check("flush_cnt", 32'(DOUT_CNT), 32'd3);
    tick(1);
    drive(2'd0, 1'b0, 1'b1);
    check("flush_empty_noop", 32'(DOUT_DV), 32'd0);
    tick(2);
    check("flush_empty_noop_late", 32'(DOUT_DV), 32'd0);

    // Overflow: stalled output, 12 samples -> words 1,2 held, word 3 dropped
    DOUT_RDY = 1'b0;
    exp_q.push_back({3'd4, 8'h55});
    exp_q.push_back({3'd4, 8'hAA});
    for (int i = 0; i < 4; i++) drive(2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(2'd2, 1'b1, 1'b0);
    check("ovf_full_no_flag", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 4; i++) drive(2'd3, 1'b1, 1'b0);
    check("ovf_set", 32'(OVERFLOW), 32'd1);
    check("ovf_head_kept", 32'(DOUT), 32'h55);
`ifdef STREAM_PACKER_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(DROP_CNT), 32'd1);
`endif
    tick(2);
    check("stall_dout_stable", 32'(DOUT), 32'h55);
    check("stall_cnt_stable", 32'(DOUT_CNT), 32'd4);
    check("stall_dv_stable", 32'(DOUT_DV), 32'd1);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    check("ovf_clr", 32'(OVERFLOW), 32'd0);
`ifdef STREAM_PACKER_DROP_CNT_EN
    check("ovf_clr_drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
    // Drop in the same cycle as OVF_CLR: set wins
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    OVF_CLR = 1'b1;
    drive(2'd3, 1'b1, 1'b0);
    OVF_CLR = 1'b0;
    check("ovf_set_priority", 32'(OVERFLOW), 32'd1);
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    check("ovf_clr_again", 32'(OVERFLOW), 32'd0);
    DOUT_RDY = 1'b1;
    tick(1);
    check("drain_second_word", 32'(DOUT), 32'hAA);
    tick(1);
    check("drain_empty", 32'(DOUT_DV), 32'd0);

    // Push while full with a pop in the same cycle: order A,B,C, no overflow
    DOUT_RDY = 1'b0;
    exp_q.push_back({3'd4, 8'h11});
    exp_q.push_back({3'd4, 8'h22});
    exp_q.push_back({3'd4, 8'h0F});
    drive(2'd1, 1'b1, 1'b0);
    drive(2'd0, 1'b1, 1'b0);
    drive(2'd1, 1'b1, 1'b0);
    drive(2'd0, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    drive(2'd0, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    drive(2'd0, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd3, 1'b1, 1'b0);
    drive(2'd0, 1'b1, 1'b0);
    DOUT_RDY = 1'b1;
    drive(2'd0, 1'b1, 1'b0);
    check("pushfull_no_ovf", 32'(OVERFLOW), 32'd0);
    check("pushfull_head", 32'(DOUT), 32'h22);
    tick(1);
    check("pushfull_third", 32'(DOUT), 32'h0F);
    tick(1);
    check("pushfull_drained", 32'(DOUT_DV), 32'd0);

    // Reset mid-operation: a buffered word and a 2-sample partial are discarded
    DOUT_RDY = 1'b0;
    for (int i = 0; i < 4; i++) drive(2'd3, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    check("prereset_dv", 32'(DOUT_DV), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    check("async_rst_dv", 32'(DOUT_DV), 32'd0);
    check("async_rst_dout", 32'(DOUT), 32'd0);
    RST_N = 1'b1;
    DOUT_RDY = 1'b1;
    tick(1);
    exp_q.push_back({3'd4, 8'h55});
    for (int i = 0; i < 4; i++) drive(2'd1, 1'b1, 1'b0);
    check("post_rst_word", 32'(DOUT), 32'h55);
    check("post_rst_cnt", 32'(DOUT_CNT), 32'd4);
    tick(1);
    check("post_rst_single", 32'(DOUT_DV), 32'd0);

    // FLUSH together with the final sample -> one full word only
    drive(2'd1, 1'b1, 1'b0);
    drive(2'd1, 1'b1, 1'b0);
    drive(2'd1, 1'b1, 1'b0);
    exp_q.push_back({3'd4, 8'h95});
    drive(2'd2, 1'b1, 1'b1);
    check("flush_last_dout", 32'(DOUT), 32'h95);
    check("flush_last_cnt", 32'(DOUT_CNT), 32'd4);
    tick(1);
    check("flush_last_no_extra", 32'(DOUT_DV), 32'd0);
    tick(3);
    check("flush_last_no_extra_late", 32'(DOUT_DV), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
